serial_and_collector_16: RTL and testbench
==========================================

SERIAL_AND_COLLECTOR_16 -- requirements
Module: serial_and_collector_16

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, which sets the result word width in bits.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port start, input, 1 bit: a one-cycle request to begin collecting a new word.
REQ-005 The block SHALL provide port bit_valid, input, 1 bit: qualifies a_bit/b_bit on the current cycle.
REQ-006 The block SHALL provide port a_bit, input, 1 bit: serial operand A, LSB first.
REQ-007 The block SHALL provide port b_bit, input, 1 bit: serial operand B, LSB first.
REQ-008 The block SHALL provide port out, output, WIDTH bits: the assembled result, bit i = a_i & b_i.
REQ-009 The block SHALL provide port busy, output, 1 bit: high while collecting bits.
REQ-010 The block SHALL provide port done, output, 1 bit: a one-cycle pulse when out holds a complete word.

Function
REQ-011 The FSM SHALL have the states IDLE, COLLECT and DONE.
REQ-012 In IDLE, start=1 SHALL move to COLLECT next cycle, clear out to 0 and set the bit index to 0.
REQ-013 In IDLE, bit_valid SHALL be ignored.
REQ-014 In COLLECT, each cycle with bit_valid=1 SHALL write out[index] <= a_bit & b_bit and increment index.
REQ-015 In COLLECT, cycles with bit_valid=0 SHALL leave out and index unchanged; gaps of any length are legal.
REQ-016 When the bit at index WIDTH-1 is captured, the FSM SHALL go to DONE on the next edge and index SHALL wrap to 0.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-018 start asserted in COLLECT SHALL be ignored; no restart and no corruption of the word in progress.
REQ-019 start asserted in DONE SHALL be ignored; a new word requires start in IDLE.
REQ-020 busy SHALL equal 1 exactly in COLLECT; done SHALL equal 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-021 out SHALL hold its last complete value from DONE through IDLE until the next accepted start clears it.
REQ-022 Latency from accepting start to done SHALL be WIDTH+2 cycles with bit_valid held at 1: one cycle to enter COLLECT, WIDTH capture cycles, then DONE.
REQ-023 The index counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never address outside out.
REQ-024 out bits not yet captured during COLLECT SHALL read 0.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, index=0, out=0, busy=0 and done=0.
REQ-026 Reset asserted mid-COLLECT SHALL discard the partial word; after release the block SHALL wait for a new start.
REQ-027 The first rising clk edge after rst_n deasserts SHALL behave as normal IDLE operation.

Structure
REQ-028 The state encodings (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2) and the default WIDTH SHALL live in a shared header included by this block and its bench.
REQ-029 The index counter SHALL be one sub-module, bit_index_counter, with clk, rst_n, clear, inc and a count output that wraps at WIDTH-1.
REQ-030 The FSM and the out register SHALL reside in serial_and_collector_16.

Verification
REQ-031 The bench SHALL cover reset then idle: rst_n low then high, no start, 20 cycles -> out=0x0000, busy=0, done=0 throughout.
REQ-032 The bench SHALL cover a full word: start, then 16 contiguous bit_valid cycles with A=0xF0F0 and B=0xFF00 LSB first -> done pulse on cycle 18 after start; out=0xF000.
REQ-033 The bench SHALL cover gapped input: A=0xFFFF, B=0xA5A5, with bit_valid low every other cycle -> out=0xA5A5; done only after the 16th valid bit.
REQ-034 The bench SHALL cover ignored start: start pulsed at bit 7 of a word with A=B=0x1234 -> completes normally with out=0x1234, exactly one done pulse.
REQ-035 The bench SHALL cover reset mid-word: rst_n low after 5 bits -> out=0, busy=0 at once; a following word with A=B=0xFFFF -> out=0xFFFF.
REQ-036 The bench SHALL cover back-to-back words: start issued the cycle after done, with words 0x00FF&0x0FF0 and then 0xFFFF&0x8001 -> out=0x00F0, then 0x8001; out is cleared when the second start is accepted.

Source files
------------

// File: rtl/serial_and_collector_16_pkg.sv
// Shared definitions for the serial AND collector and its bench.
package serial_and_collector_16_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Index width for a word of the given size; never zero.
    function automatic int unsigned index_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_and_collector_16_index.sv
// Bit index counter: clears on request, advances on inc, wraps after WIDTH-1.
module bit_index_counter
    import serial_and_collector_16_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = index_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Index register; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_and_collector_16.sv
// Collects two LSB-first serial operands and assembles their bitwise AND.
module serial_and_collector_16
    import serial_and_collector_16_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   IW   = index_width(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t        state;
    state_t        state_next;
    logic          clear;
    logic          inc;
    logic [IW-1:0] index;

    bit_index_counter #(
        .WIDTH (WIDTH),
        .CW    (IW)
    ) u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (inc),
        .count (index)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and counter/word controls; start only matters in IDLE.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    clear      = 1'b1;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    inc = 1'b1;
                    if (index == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from state so reset clears them at once.
    always_comb begin
        busy = (state == COLLECT);
        done = (state == DONE);
    end

    // Result word: cleared on an accepted start, one AND bit per valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clear) begin
            out <= '0;
        end else if (inc) begin
            out[index] <= a_bit & b_bit;
        end
    end

endmodule

// File: tb/tb_serial_and_collector_16.sv
// Scoreboard bench for serial_and_collector_16.
module tb_serial_and_collector_16;
    import serial_and_collector_16_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bit_valid = 1'b0;
    logic         a_bit = 1'b0;
    logic         b_bit = 1'b0;
    logic [W-1:0] out;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           last_done_cyc = -1;
    logic [W-1:0] sb[$];

    serial_and_collector_16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // busy and done are mutually exclusive whenever the block is out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (busy && done) begin
                n_bad++;
                $display("FAIL busy_done_excl: busy=%b done=%b required not both 1", busy, done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic send_start(input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(a & b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit gapped, input int start_at,
                             input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (gapped) begin
                bit_valid = 1'b0;
                a_bit     = 1'b1;
                b_bit     = 1'b1;
                tick();
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            start     = (i == start_at);
            tick();
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (out !== '0) begin
                n_bad++;
                $display("FAIL reset_idle_out: cycle %0d got %h required %h", i, out, 16'h0000);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_busy: cycle %0d got %b required 0", i, busy);
            end
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_done: cycle %0d got %b required 0", i, done);
            end
        end
    endtask

    task automatic test_full_word();
        int s;
        int d0;
        logic [W-1:0] exp;
        s  = cyc;
        d0 = done_cnt;
        send_start(16'hF0F0, 16'hFF00);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_busy: got %b required 1", busy);
        end
        send_bits(16'hF0F0, 16'hFF00, 1'b0, -1, 0, W - 1);
        n_cmp++;
        if (done_cnt - d0 != 1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL full_done: pulses %0d done %b required 1 pulse now", done_cnt - d0, done);
        end
        n_cmp++;
        if (last_done_cyc - s + 1 != int'(W) + 2) begin
            n_bad++;
            $display("FAIL full_latency: got %0d cycles required %0d", last_done_cyc - s + 1, W + 2);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp) begin
            n_bad++;
            $display("FAIL full_out: got %h required %h", out, exp);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== exp) begin
            n_bad++;
            $display("FAIL full_hold: done %b busy %b out %h required 0 0 %h", done, busy, out, exp);
        end
    endtask

    task automatic test_gapped();
        int d0;
        logic [W-1:0] exp;
        send_start(16'hFFFF, 16'hA5A5);
        d0 = done_cnt;
        send_bits(16'hFFFF, 16'hA5A5, 1'b1, -1, 0, 7);
        n_cmp++;
        if (out !== 16'h00A5 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_partial: out %h busy %b required 00a5 1", out, busy);
        end
        n_cmp++;
        if (done_cnt != d0) begin
            n_bad++;
            $display("FAIL gap_early_done: got %0d pulses required 0", done_cnt - d0);
        end
        send_bits(16'hFFFF, 16'hA5A5, 1'b1, -1, 8, W - 1);
        n_cmp++;
        if (done_cnt - d0 != 1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_done: pulses %0d done %b required 1 pulse now", done_cnt - d0, done);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp) begin
            n_bad++;
            $display("FAIL gap_out: got %h required %h", out, exp);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int d0;
        logic [W-1:0] exp;
        d0 = done_cnt;
        send_start(16'h1234, 16'h1234);
        send_bits(16'h1234, 16'h1234, 1'b0, 7, 0, W - 1);
        n_cmp++;
        if (done_cnt - d0 != 1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL ign_done: pulses %0d done %b required 1 pulse now", done_cnt - d0, done);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp) begin
            n_bad++;
            $display("FAIL ign_out: got %h required %h", out, exp);
        end
        // start during DONE must not begin a new word
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_done_start: busy %b done %b required 0 0", busy, done);
        end
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || out !== exp || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL ign_after: busy %b out %h pulses %0d required 0 %h 1", busy, out, done_cnt - d0, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        send_start(16'hFFFF, 16'hFFFF);
        send_bits(16'hFFFF, 16'hFFFF, 1'b0, -1, 0, 4);
        rst_n = 1'b0;
        #1;
        if (sb.size() > 0) void'(sb.pop_back());
        n_cmp++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_async: out %h busy %b done %b required 0000 0 0", out, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        // valid bits with no start must be ignored in IDLE
        bit_valid = 1'b1;
        a_bit     = 1'b1;
        b_bit     = 1'b1;
        repeat (3) tick();
        bit_valid = 1'b0;
        n_cmp++;
        if (out !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_idle: out %h busy %b required 0000 0", out, busy);
        end
        send_start(16'hFFFF, 16'hFFFF);
        send_bits(16'hFFFF, 16'hFFFF, 1'b0, -1, 0, W - 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp || done !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_word: out %h done %b required %h 1", out, done, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        send_start(16'h00FF, 16'h0FF0);
        send_bits(16'h00FF, 16'h0FF0, 1'b0, -1, 0, W - 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp || done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first: out %h done %b required %h 1", out, done, exp);
        end
        tick();
        n_cmp++;
        if (out !== exp || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_hold: out %h busy %b required %h 0", out, busy, exp);
        end
        send_start(16'hFFFF, 16'h8001);
        n_cmp++;
        if (out !== '0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_clear: out %h busy %b required 0000 1", out, busy);
        end
        send_bits(16'hFFFF, 16'h8001, 1'b0, -1, 0, W - 1);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (out !== exp || done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second: out %h done %b required %h 1", out, done, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_gapped();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
